// File: rtl/adc_responder.sv
// adc_responder: synthesizable responder for an 8-channel serial ADC (ADC128S022-style).
// All pins are oversampled on clk_50. The 3-bit channel address is decoded from din, and
// the addressed 12-bit sample is returned MSB first on dout in the following frame.
// Optional build macro ADC_RESPONDER_PROTO_CHECK_EN adds a sticky protocol checker on
// proto_err. When the macro is not defined, proto_err is tied low.
module adc_responder #(
    parameter int SYNC_STAGES = 2,
    parameter int DATA_W      = 12
) (
    input  logic                clk_50,
    input  logic                rst_n,
    input  logic                adc_cs_n,
    input  logic                adc_sck,
    input  logic                din,
    input  logic [8*DATA_W-1:0] ch_data,
    output logic                dout,
    output logic                frame_done,
    output logic [2:0]          last_addr,
    output logic                busy,
    output logic                proto_err
);

    localparam int FRAME_LEN = DATA_W + 4;
    localparam int CNT_W     = $clog2(FRAME_LEN);

    localparam logic [CNT_W-1:0] CNT_LAST   = CNT_W'(FRAME_LEN - 1);
    localparam logic [CNT_W-1:0] FIRST_DATA = CNT_W'(4);
    localparam logic [CNT_W-1:0] RISE_ADDR2 = CNT_W'(2);
    localparam logic [CNT_W-1:0] RISE_ADDR1 = CNT_W'(3);
    localparam logic [CNT_W-1:0] RISE_ADDR0 = CNT_W'(4);

    typedef enum logic {
        IDLE,
        FRAME
    } state_t;

    state_t state_q, state_d;

    logic [SYNC_STAGES-1:0] cs_sync, sck_sync, din_sync;
    logic                   cs_dly, sck_dly;
    logic                   cs_s, sck_s, din_s;
    logic                   cs_fall, cs_rise, sck_rise, sck_fall;

    logic [CNT_W-1:0]  rise_q, rise_d;
    logic [CNT_W-1:0]  fall_q, fall_d, fall_nx;
    logic [2:0]        addr_q, addr_d;
    logic [2:0]        next_addr_q, next_addr_d;
    logic [DATA_W-1:0] shreg_q, shreg_d;
    logic              dout_q, dout_d;
    logic              done_q, done_d;
    logic              busy_q, busy_d;

    logic [DATA_W-1:0] chan [8];

    // Pin synchronizers plus one extra delay flop on cs/sck for edge detection.
    // The reset values match the bus idle state so that reset release produces no false edge.
    always_ff @(posedge clk_50 or negedge rst_n) begin
        if (!rst_n) begin
            cs_sync  <= '1;
            sck_sync <= '1;
            din_sync <= '0;
            cs_dly   <= 1'b1;
            sck_dly  <= 1'b1;
        end else begin
            cs_sync  <= {cs_sync[SYNC_STAGES-2:0], adc_cs_n};
            sck_sync <= {sck_sync[SYNC_STAGES-2:0], adc_sck};
            din_sync <= {din_sync[SYNC_STAGES-2:0], din};
            cs_dly   <= cs_sync[SYNC_STAGES-1];
            sck_dly  <= sck_sync[SYNC_STAGES-1];
        end
    end

    assign cs_s     = cs_sync[SYNC_STAGES-1];
    assign sck_s    = sck_sync[SYNC_STAGES-1];
    assign din_s    = din_sync[SYNC_STAGES-1];
    assign cs_fall  = cs_dly & ~cs_s;
    assign cs_rise  = ~cs_dly & cs_s;
    assign sck_rise = ~sck_dly & sck_s;
    assign sck_fall = sck_dly & ~sck_s;

    // Unpack the channel bus into one sample per channel.
    always_comb begin
        for (int k = 0; k < 8; k++) begin
            chan[k] = ch_data[k*DATA_W +: DATA_W];
        end
    end

    // Frame sequencing: address decode on SCK rises, sample shifting on SCK falls.
    // A cs change takes priority over an SCK edge detected in the same cycle.
    always_comb begin
        state_d     = state_q;
        rise_d      = rise_q;
        fall_d      = fall_q;
        fall_nx     = (fall_q == CNT_LAST) ? '0 : fall_q + CNT_W'(1);
        addr_d      = addr_q;
        next_addr_d = next_addr_q;
        shreg_d     = shreg_q;
        dout_d      = dout_q;
        done_d      = 1'b0;
        busy_d      = busy_q;

        case (state_q)
            IDLE: begin
                dout_d = 1'b0;
                busy_d = 1'b0;
                if (cs_fall) begin
                    state_d = FRAME;
                    busy_d  = 1'b1;
                    rise_d  = '0;
                    fall_d  = '0;
                    addr_d  = '0;
                    shreg_d = chan[next_addr_q];
                end
            end

            FRAME: begin
                if (cs_rise) begin
                    state_d = IDLE;
                    busy_d  = 1'b0;
                    dout_d  = 1'b0;
                    rise_d  = '0;
                    fall_d  = '0;
                    addr_d  = '0;
                end else begin
                    if (sck_rise) begin
                        case (rise_q)
                            RISE_ADDR2: addr_d[2] = din_s;
                            RISE_ADDR1: addr_d[1] = din_s;
                            RISE_ADDR0: addr_d[0] = din_s;
                            default:    addr_d    = addr_q;
                        endcase
                        if (rise_q == CNT_LAST) begin
                            rise_d      = '0;
                            next_addr_d = addr_q;
                            done_d      = 1'b1;
                            shreg_d     = chan[addr_q];
                        end else begin
                            rise_d = rise_q + CNT_W'(1);
                        end
                    end
                    if (sck_fall) begin
                        fall_d = fall_nx;
                        if (fall_nx >= FIRST_DATA) begin
                            dout_d  = shreg_q[DATA_W-1];
                            shreg_d = {shreg_q[DATA_W-2:0], 1'b0};
                        end else begin
                            dout_d = 1'b0;
                        end
                    end
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers, all cleared by the asynchronous reset.
    always_ff @(posedge clk_50 or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            rise_q      <= '0;
            fall_q      <= '0;
            addr_q      <= '0;
            next_addr_q <= '0;
            shreg_q     <= '0;
            dout_q      <= 1'b0;
            done_q      <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            rise_q      <= rise_d;
            fall_q      <= fall_d;
            addr_q      <= addr_d;
            next_addr_q <= next_addr_d;
            shreg_q     <= shreg_d;
            dout_q      <= dout_d;
            done_q      <= done_d;
            busy_q      <= busy_d;
        end
    end

    // next_addr and last_addr always load the same value at the same time,
    // so a single register drives both.
    assign dout       = dout_q;
    assign frame_done = done_q;
    assign last_addr  = next_addr_q;
    assign busy       = busy_q;

`ifdef ADC_RESPONDER_PROTO_CHECK_EN
    logic [2:0] gap_q;
    logic       perr_q;

    // Sticky error on a truncated frame or on SCK edges less than 4 clocks apart.
    // gap_q saturates at 4 and starts there, so the first edge after reset is always legal.
    always_ff @(posedge clk_50 or negedge rst_n) begin
        if (!rst_n) begin
            gap_q  <= 3'd4;
            perr_q <= 1'b0;
        end else begin
            if (sck_rise || sck_fall) begin
                gap_q <= 3'd1;
                if (gap_q < 3'd4) begin
                    perr_q <= 1'b1;
                end
            end else if (gap_q < 3'd4) begin
                gap_q <= gap_q + 3'd1;
            end
            if ((state_q == FRAME) && cs_rise && ((rise_q != '0) || (fall_q != '0))) begin
                perr_q <= 1'b1;
            end
        end
    end

    assign proto_err = perr_q;
`else
    assign proto_err = 1'b0;
`endif

endmodule

// File: tb/tb_adc_responder.sv
// tb_adc_responder: directed bench for adc_responder.
// A frame-level behavioural model produces the expected outputs, and these are compared on every
// clock cycle. Directed frames also carry hand-computed sample words and addresses.
module tb_adc_responder;

    localparam int SYNC_STAGES = 2;
    localparam int DATA_W      = 12;
    localparam int FRAME_LEN   = DATA_W + 4;
    localparam int LAT         = SYNC_STAGES + 1;
    localparam int HALF        = 10;

    logic                clk_50   = 1'b0;
    logic                rst_n    = 1'b0;
    logic                adc_cs_n = 1'b1;
    logic                adc_sck  = 1'b1;
    logic                din      = 1'b0;
    logic [8*DATA_W-1:0] ch_data  = '0;
    logic                dout;
    logic                frame_done;
    logic [2:0]          last_addr;
    logic                busy;
    logic                proto_err;

    int n_compared   = 0;
    int n_mismatched = 0;
    bit check_en     = 1'b0;

    adc_responder #(
        .SYNC_STAGES(SYNC_STAGES),
        .DATA_W     (DATA_W)
    ) dut (
        .clk_50    (clk_50),
        .rst_n     (rst_n),
        .adc_cs_n  (adc_cs_n),
        .adc_sck   (adc_sck),
        .din       (din),
        .ch_data   (ch_data),
        .dout      (dout),
        .frame_done(frame_done),
        .last_addr (last_addr),
        .busy      (busy),
        .proto_err (proto_err)
    );

    // 50 MHz system clock
    always #10 clk_50 = ~clk_50;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        n_compared++;
        if (actual !== expected) begin
            n_mismatched++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
        end
    endtask

    // ------------------------------------------------------------------
    // Behavioural model. A pin change becomes visible to the responder
    // SYNC_STAGES+1 clocks later. The model therefore looks at the pin
    // history from that far back and applies the frame rules directly:
    // rise counts without wrapping, bit selection by index, and plain
    // cycle arithmetic for SCK edge spacing.
    // ------------------------------------------------------------------
    logic              cs_h  [SYNC_STAGES+1];
    logic              sck_h [SYNC_STAGES+1];
    logic              din_h [SYNC_STAGES+1];
    logic              cs_now, cs_was, sck_now, sck_was, din_now;
    logic              m_in_frame, m_dout, m_done, m_perr;
    logic [2:0]        m_addr, m_next;
    logic [DATA_W-1:0] m_word, m_tmp;
    int                m_rises, m_falls, m_cycle, m_last_edge, m_f;

    function automatic logic [DATA_W-1:0] chanValue(input logic [2:0] a);
        return ch_data[a*DATA_W +: DATA_W];
    endfunction

    // Model update on each clock, asynchronously cleared by reset
    always @(posedge clk_50 or negedge rst_n) begin
        if (!rst_n) begin
            for (int j = 0; j <= SYNC_STAGES; j++) begin
                cs_h[j]  = 1'b1;
                sck_h[j] = 1'b1;
                din_h[j] = 1'b0;
            end
            m_in_frame  = 1'b0;
            m_dout      = 1'b0;
            m_done      = 1'b0;
            m_perr      = 1'b0;
            m_addr      = '0;
            m_next      = '0;
            m_word      = '0;
            m_rises     = 0;
            m_falls     = 0;
            m_cycle     = 0;
            m_last_edge = -100;
        end else begin
            cs_now  = cs_h[SYNC_STAGES-1];
            cs_was  = cs_h[SYNC_STAGES];
            sck_now = sck_h[SYNC_STAGES-1];
            sck_was = sck_h[SYNC_STAGES];
            din_now = din_h[SYNC_STAGES-1];
            m_cycle++;
            m_done = 1'b0;
            if (sck_now != sck_was) begin
`ifdef ADC_RESPONDER_PROTO_CHECK_EN
                if ((m_cycle - m_last_edge) < 4) m_perr = 1'b1;
`endif
                m_last_edge = m_cycle;
            end
            if (!m_in_frame) begin
                m_dout = 1'b0;
                if (cs_was && !cs_now) begin
                    m_in_frame = 1'b1;
                    m_word     = chanValue(m_next);
                    m_rises    = 0;
                    m_falls    = 0;
                end
            end else if (cs_now && !cs_was) begin
`ifdef ADC_RESPONDER_PROTO_CHECK_EN
                if ((m_rises % FRAME_LEN) != 0 || (m_falls % FRAME_LEN) != 0) m_perr = 1'b1;
`endif
                m_in_frame = 1'b0;
                m_dout     = 1'b0;
            end else if (sck_now && !sck_was) begin
                m_rises++;
                if (((m_rises - 1) % FRAME_LEN) inside {2, 3, 4}) m_addr = {m_addr[1:0], din_now};
                if ((m_rises % FRAME_LEN) == 0) begin
                    m_next = m_addr;
                    m_done = 1'b1;
                    m_word = chanValue(m_addr);
                end
            end else if (!sck_now && sck_was) begin
                m_falls++;
                m_f = m_falls % FRAME_LEN;
                if (m_f >= 4) begin
                    m_tmp  = m_word >> (DATA_W + 3 - m_f);
                    m_dout = m_tmp[0];
                end else begin
                    m_dout = 1'b0;
                end
            end
            for (int j = SYNC_STAGES; j > 0; j--) begin
                cs_h[j]  = cs_h[j-1];
                sck_h[j] = sck_h[j-1];
                din_h[j] = din_h[j-1];
            end
            cs_h[0]  = adc_cs_n;
            sck_h[0] = adc_sck;
            din_h[0] = din;
        end
    end

    // Cycle-by-cycle comparison against the model, on the inactive clock edge
    always @(negedge clk_50) begin
        if (check_en) begin
            checkOutput("dout",       32'(dout),       32'(m_dout));
            checkOutput("frame_done", 32'(frame_done), 32'(m_done));
            checkOutput("last_addr",  32'(last_addr),  32'(m_next));
            checkOutput("busy",       32'(busy),       32'(m_in_frame));
            checkOutput("proto_err",  32'(proto_err),  32'(m_perr));
        end
    end

    // ------------------------------------------------------------------
    // Stimulus helpers. Inputs change 1 ns after a rising clock edge.
    // ------------------------------------------------------------------
    task automatic tick(input int n);
        repeat (n) @(posedge clk_50);
        #1;
    endtask

    task automatic applyStimulus(input logic cs_v, input logic sck_v, input logic din_v, input int hold);
        adc_cs_n = cs_v;
        adc_sck  = sck_v;
        din      = din_v;
        tick(hold);
    endtask

    task automatic setChannel(input int k, input logic [DATA_W-1:0] v);
        ch_data[k*DATA_W +: DATA_W] = v;
    endtask

    // Drives n SCK cycles (fall, then rise) carrying addr in control bits 13..11.
    // It collects the dout bits seen after falls 4..15, and dout sampled one clock before DB11 is due.
    task automatic runSck(input logic [2:0] addr, input int n_cycles, input int half,
                          output logic [DATA_W-1:0] word, output logic early);
        logic [15:0] ctrl;
        logic [3:0]  bidx;
        ctrl       = '0;
        ctrl[13:11] = addr;
        word       = '0;
        early      = 1'b0;
        for (int i = 1; i <= n_cycles; i++) begin
            bidx    = 4'(16 - i);
            adc_sck = 1'b0;
            din     = ctrl[bidx];
            if (i == 4 && half > LAT) begin
                tick(LAT - 1);
                early = dout;
                tick(half - (LAT - 1));
            end else begin
                tick(half);
            end
            if (i >= 4 && i <= 15) word = {word[DATA_W-2:0], dout};
            adc_sck = 1'b1;
            tick(half);
        end
    endtask

    task automatic sendFrame(input string tag, input logic [2:0] addr,
                             input logic [DATA_W-1:0] exp_word, input bit use_cs);
        logic [DATA_W-1:0] word;
        logic              early;
        if (use_cs) begin
            adc_cs_n = 1'b0;
            tick(6);
        end
        runSck(addr, 16, HALF, word, early);
        checkOutput({tag, " pre-DB11 dout"}, 32'(early), 32'(0));
        checkOutput({tag, " word"}, 32'(word), 32'(exp_word));
        checkOutput({tag, " last_addr"}, 32'(last_addr), 32'(addr));
        if (use_cs) begin
            adc_cs_n = 1'b1;
            tick(8);
        end
    endtask

    initial begin
        logic [DATA_W-1:0] w;
        logic              e;

        setChannel(0, 12'h000);
        setChannel(1, 12'h111);
        setChannel(2, 12'h222);
        setChannel(3, 12'h333);
        setChannel(4, 12'h444);
        setChannel(5, 12'd1118);
        setChannel(6, 12'd1998);
        setChannel(7, 12'd3802);

        $display("[TB] reset state");
        applyStimulus(1'b1, 1'b1, 1'b0, 3);
        check_en = 1'b1;
        checkOutput("reset dout",       32'(dout),       32'(0));
        checkOutput("reset frame_done", 32'(frame_done), 32'(0));
        checkOutput("reset last_addr",  32'(last_addr),  32'(0));
        checkOutput("reset busy",       32'(busy),       32'(0));
        checkOutput("reset proto_err",  32'(proto_err),  32'(0));
        rst_n = 1'b1;
        tick(5);

        $display("[TB] continuous frames, cs held low");
        applyStimulus(1'b0, 1'b1, 1'b0, 6);
        checkOutput("busy in frame", 32'(busy), 32'(1));
        sendFrame("frame0", 3'd5, 12'h000, 1'b0);
        sendFrame("frame1", 3'd6, 12'h45E, 1'b0);
        sendFrame("frame2", 3'd7, 12'h7CE, 1'b0);
        sendFrame("frame3", 3'd2, 12'hEDA, 1'b0);
        applyStimulus(1'b1, 1'b1, 1'b0, 8);
        checkOutput("busy after frames", 32'(busy), 32'(0));
        checkOutput("proto_err clean",   32'(proto_err), 32'(0));

        $display("[TB] truncated frame");
        applyStimulus(1'b0, 1'b1, 1'b0, 6);
        runSck(3'd3, 9, HALF, w, e);
        applyStimulus(1'b1, 1'b1, 1'b0, LAT + 1);
        checkOutput("truncate busy",      32'(busy),      32'(0));
        checkOutput("truncate last_addr", 32'(last_addr), 32'(2));
`ifdef ADC_RESPONDER_PROTO_CHECK_EN
        checkOutput("truncate proto_err", 32'(proto_err), 32'(1));
`else
        checkOutput("truncate proto_err", 32'(proto_err), 32'(0));
`endif
        sendFrame("after truncate", 3'd1, 12'h222, 1'b1);

        $display("[TB] reset mid-frame");
        applyStimulus(1'b0, 1'b1, 1'b0, 6);
        runSck(3'd4, 7, HALF, w, e);
        checkOutput("pre-reset dout DB8", 32'(dout), 32'(1));
        rst_n = 1'b0;
        #1;
        checkOutput("async reset dout",       32'(dout),       32'(0));
        checkOutput("async reset frame_done", 32'(frame_done), 32'(0));
        checkOutput("async reset last_addr",  32'(last_addr),  32'(0));
        checkOutput("async reset busy",       32'(busy),       32'(0));
        checkOutput("async reset proto_err",  32'(proto_err),  32'(0));
        applyStimulus(1'b1, 1'b1, 1'b0, 3);
        rst_n = 1'b1;
        tick(4);
        setChannel(0, 12'hA5C);
        sendFrame("post-reset ch0", 3'd6, 12'hA5C, 1'b1);

        $display("[TB] ch_data changes around the snapshot");
        fork
            sendFrame("in-flight ch6", 3'd3, 12'h7CE, 1'b1);
            begin
                tick(150);
                setChannel(6, 12'h0F0);
            end
        join
        sendFrame("ch3", 3'd0, 12'h333, 1'b1);
        fork
            sendFrame("late change ch0", 3'd4, 12'hA5C, 1'b1);
            begin
                tick(5);
                setChannel(0, 12'h123);
            end
        join
        sendFrame("ch4", 3'd7, 12'h444, 1'b1);
        sendFrame("ch7", 3'd0, 12'hEDA, 1'b1);
        sendFrame("new ch0", 3'd5, 12'h123, 1'b1);

        $display("[TB] fast SCK");
        rst_n = 1'b0;
        tick(2);
        rst_n = 1'b1;
        tick(4);
        applyStimulus(1'b0, 1'b1, 1'b0, 6);
        runSck(3'd0, 16, 2, w, e);
        applyStimulus(1'b1, 1'b1, 1'b0, 8);
`ifdef ADC_RESPONDER_PROTO_CHECK_EN
        checkOutput("fast sck proto_err", 32'(proto_err), 32'(1));
`else
        checkOutput("fast sck proto_err", 32'(proto_err), 32'(0));
`endif

        check_en = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule
